// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - checks a two-way signal controller's lamp sequence and phase timing
module traffic_light_monitor (
  input  logic       clk,
  input  logic       rst,
  input  logic       G1,
  input  logic       Y1,
  input  logic       R1,
  input  logic       G2,
  input  logic       Y2,
  input  logic       R2,
  input  logic [5:0] Tgreen,
  input  logic [5:0] Tyellow,
  input  logic       clr_err,
  output logic [1:0] phase,
  output logic [7:0] phase_len,
  output logic [1:0] len_phase,
  output logic       len_valid,
  output logic       err_timing,
  output logic       err_seq,
  output logic       err_illegal,
  output logic       locked,
  output logic [7:0] cycles_done
);

  typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_t;

  localparam logic [2:0] DEC_OFF = 3'd4;
  localparam logic [2:0] DEC_ILL = 3'd5;

  state_t     state;
  logic [5:0] lights;
  logic [5:0] lights_q;
  logic [7:0] run;
  logic [2:0] dec;
  logic       change;
  logic       illegal;
  logic       track_edge;
  logic [1:0] succ;
  logic [7:0] exp_len;
  logic       set_timing;
  logic       set_seq;

  assign lights = {G1, Y1, R1, G2, Y2, R2};

  // Decodes 0..3 are phase indices so dec[1:0] compares directly against phase.
  always_comb begin
    dec = DEC_ILL;
    case (lights)
      6'b100001: dec = 3'd0;
      6'b010001: dec = 3'd1;
      6'b001100: dec = 3'd2;
      6'b001010: dec = 3'd3;
      6'b000000: dec = DEC_OFF;
      default:   dec = DEC_ILL;
    endcase
  end

  assign change     = (lights != lights_q);
  assign illegal    = (dec == DEC_ILL);
  assign succ       = phase + 2'd1;
  assign exp_len    = phase[0] ? {2'b00, Tyellow} : {2'b00, Tgreen};
  assign track_edge = (state == TRACK) && change && !illegal;
  assign set_timing = track_edge && (run != exp_len);
  assign set_seq    = track_edge && (dec != {1'b0, succ});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      lights_q    <= 6'b000000;
      run         <= 8'd0;
      phase       <= 2'd0;
      phase_len   <= 8'd0;
      len_phase   <= 2'd0;
      len_valid   <= 1'b0;
      err_timing  <= 1'b0;
      err_seq     <= 1'b0;
      err_illegal <= 1'b0;
      locked      <= 1'b0;
      cycles_done <= 8'd0;
    end else begin
      lights_q <= lights;
      if (change)
        run <= 8'd1;
      else if (run != 8'hff)
        run <= run + 8'd1;
      len_valid <= 1'b0;

      // A flag detected on the clearing edge survives the clear.
      err_timing  <= set_timing | (err_timing & ~clr_err);
      err_seq     <= set_seq | (err_seq & ~clr_err);
      err_illegal <= illegal | (err_illegal & ~clr_err);

      if (illegal) begin
        state  <= FAULT;
        locked <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (change && dec == 3'd0) begin
              state  <= TRACK;
              phase  <= 2'd0;
              locked <= 1'b1;
            end
          end
          TRACK: begin
            if (change) begin
              phase_len <= run;
              len_phase <= phase;
              len_valid <= 1'b1;
              if (set_seq) begin
                state  <= IDLE;
                locked <= 1'b0;
              end else begin
                phase <= succ;
                if (phase == 2'd3)
                  cycles_done <= cycles_done + 8'd1;
              end
            end
          end
          FAULT: begin
            if (clr_err)
              state <= IDLE;
          end
          default: begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb/tb_traffic_light_monitor.sv - scoreboard bench for traffic_light_monitor
module tb_traffic_light_monitor;

  localparam logic [5:0] L_P0  = 6'b100001;
  localparam logic [5:0] L_P1  = 6'b010001;
  localparam logic [5:0] L_P2  = 6'b001100;
  localparam logic [5:0] L_P3  = 6'b001010;
  localparam logic [5:0] L_OFF = 6'b000000;
  localparam logic [5:0] L_BAD = 6'b100100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] lamps = 6'b000000;
  logic [5:0] Tgreen = 6'd5;
  logic [5:0] Tyellow = 6'd2;
  logic       clr_err = 1'b0;
  logic [1:0] phase;
  logic [7:0] phase_len;
  logic [1:0] len_phase;
  logic       len_valid;
  logic       err_timing;
  logic       err_seq;
  logic       err_illegal;
  logic       locked;
  logic [7:0] cycles_done;

  int n_checks = 0;
  int n_fail = 0;
  logic [9:0] exp_q[$];

  traffic_light_monitor dut (
    .clk(clk), .rst(rst),
    .G1(lamps[5]), .Y1(lamps[4]), .R1(lamps[3]),
    .G2(lamps[2]), .Y2(lamps[1]), .R2(lamps[0]),
    .Tgreen(Tgreen), .Tyellow(Tyellow), .clr_err(clr_err),
    .phase(phase), .phase_len(phase_len), .len_phase(len_phase), .len_valid(len_valid),
    .err_timing(err_timing), .err_seq(err_seq), .err_illegal(err_illegal),
    .locked(locked), .cycles_done(cycles_done)
  );

  always #5 clk = ~clk;

  // Scoreboard: every strobe must match the oldest expected {phase_len, len_phase}.
  always @(negedge clk) begin
    if (!rst && len_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL len_strobe: unexpected strobe phase_len=%0d len_phase=%0d", phase_len, len_phase);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        if ({phase_len, len_phase} !== e) begin
          n_fail++;
          $display("FAIL len_strobe: got len=%0d ph=%0d expected len=%0d ph=%0d",
                   phase_len, len_phase, e[9:2], e[1:0]);
        end
      end
    end
  end

  task automatic hold(input logic [5:0] p, input int n);
    lamps = p;
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int len, input int ph);
    exp_q.push_back({8'(len), 2'(ph)});
  endtask

  task automatic do_reset();
    lamps = L_OFF;
    clr_err = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({phase, phase_len, len_phase, len_valid, err_timing, err_seq, err_illegal, locked, cycles_done} !== 25'd0) begin
      n_fail++;
      $display("FAIL reset_state: got phase=%0d len=%0d lph=%0d lv=%0d errs=%b%b%b locked=%0d cyc=%0d expected all 0",
               phase, phase_len, len_phase, len_valid, err_timing, err_seq, err_illegal, locked, cycles_done);
    end
    rst = 1'b0;
  endtask

  task automatic test_normal();
    do_reset();
    hold(L_OFF, 3);
    hold(L_P0, 1);
    n_checks++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL normal_lock: got %0d expected 1", locked); end
    hold(L_P0, 4); push(5, 0);
    hold(L_P1, 2); push(2, 1);
    hold(L_P2, 5); push(5, 2);
    hold(L_P3, 2); push(2, 3);
    hold(L_P0, 1);
    #2;
    n_checks++;
    if ({cycles_done, err_timing, err_seq, err_illegal, locked, phase} !== {8'd1, 3'b000, 1'b1, 2'd0}) begin
      n_fail++;
      $display("FAIL normal_end: got cyc=%0d errs=%b%b%b locked=%0d phase=%0d expected cyc=1 errs=000 locked=1 phase=0",
               cycles_done, err_timing, err_seq, err_illegal, locked, phase);
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL normal_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_timing();
    do_reset();
    hold(L_OFF, 2);
    hold(L_P0, 6); push(6, 0);
    hold(L_P1, 1);
    n_checks++;
    if ({err_timing, locked} !== 2'b11) begin
      n_fail++; $display("FAIL timing_err: got err_timing=%0d locked=%0d expected 1 1", err_timing, locked);
    end
    hold(L_P1, 1); push(2, 1);
    hold(L_P2, 1);
    clr_err = 1'b1;
    hold(L_P2, 1);
    clr_err = 1'b0;
    #2;
    n_checks++;
    if ({err_timing, err_seq, locked, phase} !== {1'b0, 1'b0, 1'b1, 2'd2}) begin
      n_fail++; $display("FAIL timing_clear: got err_timing=%0d err_seq=%0d locked=%0d phase=%0d expected 0 0 1 2",
                         err_timing, err_seq, locked, phase);
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL timing_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_sequence();
    do_reset();
    hold(L_OFF, 2);
    hold(L_P0, 5); push(5, 0);
    hold(L_P2, 1);
    n_checks++;
    if ({err_seq, err_timing, locked} !== 3'b100) begin
      n_fail++; $display("FAIL seq_err: got err_seq=%0d err_timing=%0d locked=%0d expected 1 0 0", err_seq, err_timing, locked);
    end
    hold(L_P3, 2);
    n_checks++;
    if (locked !== 1'b0) begin n_fail++; $display("FAIL seq_idle: got locked=%0d expected 0", locked); end
    hold(L_P0, 1);
    #2;
    n_checks++;
    if ({locked, phase} !== {1'b1, 2'd0}) begin
      n_fail++; $display("FAIL seq_relock: got locked=%0d phase=%0d expected 1 0", locked, phase);
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL seq_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_illegal();
    do_reset();
    hold(L_OFF, 2);
    hold(L_P0, 3);
    hold(L_BAD, 1);
    n_checks++;
    if ({err_illegal, err_timing, err_seq, locked, len_valid} !== 5'b10000) begin
      n_fail++; $display("FAIL illegal_err: got ill=%0d tim=%0d seq=%0d locked=%0d lv=%0d expected 1 0 0 0 0",
                         err_illegal, err_timing, err_seq, locked, len_valid);
    end
    clr_err = 1'b1;
    hold(L_BAD, 1);
    clr_err = 1'b0;
    n_checks++;
    if (err_illegal !== 1'b1) begin n_fail++; $display("FAIL illegal_clr_same_edge: got %0d expected 1", err_illegal); end
    hold(L_OFF, 1);
    hold(L_P0, 3);
    n_checks++;
    if (locked !== 1'b0) begin n_fail++; $display("FAIL illegal_fault_hold: got locked=%0d expected 0", locked); end
    clr_err = 1'b1;
    hold(L_P0, 1);
    clr_err = 1'b0;
    n_checks++;
    if ({err_illegal, locked} !== 2'b00) begin
      n_fail++; $display("FAIL illegal_clear: got ill=%0d locked=%0d expected 0 0", err_illegal, locked);
    end
    hold(L_OFF, 1);
    hold(L_P0, 1);
    #2;
    n_checks++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL illegal_relock: got locked=%0d expected 1", locked); end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL illegal_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_saturation_reset();
    do_reset();
    Tgreen = 6'd63;
    hold(L_OFF, 1);
    hold(L_P0, 300); push(255, 0);
    hold(L_P1, 1);
    n_checks++;
    if ({err_timing, locked, phase} !== {1'b1, 1'b1, 2'd1}) begin
      n_fail++; $display("FAIL sat_err: got err_timing=%0d locked=%0d phase=%0d expected 1 1 1", err_timing, locked, phase);
    end
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({phase, phase_len, len_phase, len_valid, err_timing, err_seq, err_illegal, locked, cycles_done} !== 25'd0) begin
      n_fail++; $display("FAIL async_reset: got phase=%0d len=%0d lph=%0d lv=%0d errs=%b%b%b locked=%0d cyc=%0d expected all 0",
                         phase, phase_len, len_phase, len_valid, err_timing, err_seq, err_illegal, locked, cycles_done);
    end
    @(negedge clk);
    rst = 1'b0;
    hold(L_P1, 2);
    hold(L_P2, 2);
    n_checks++;
    if (locked !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: got locked=%0d expected 0", locked); end
    hold(L_P0, 1);
    #2;
    n_checks++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL post_reset_relock: got locked=%0d expected 1", locked); end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL sat_drain: got %0d pending expected 0", exp_q.size()); end
    Tgreen = 6'd5;
  endtask

  task automatic test_wrap();
    do_reset();
    hold(L_OFF, 1);
    for (int i = 0; i <= 256; i++) begin
      hold(L_P0, 1);
      if (i == 255 || i == 256 || i == 1) begin
        n_checks++;
        if (cycles_done !== 8'(i)) begin
          n_fail++; $display("FAIL wrap_count_%0d: got %0d expected %0d", i, cycles_done, 8'(i));
        end
      end
      if (i < 256) begin
        hold(L_P0, 4); push(5, 0);
        hold(L_P1, 2); push(2, 1);
        hold(L_P2, 5); push(5, 2);
        hold(L_P3, 2); push(2, 3);
      end
    end
    #2;
    n_checks++;
    if ({err_timing, err_seq, err_illegal, locked} !== 4'b0001) begin
      n_fail++; $display("FAIL wrap_flags: got errs=%b%b%b locked=%0d expected 000 1", err_timing, err_seq, err_illegal, locked);
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL wrap_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_timing();
    test_sequence();
    test_illegal();
    test_saturation_reset();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_light_monitor.md
TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 The block SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 The block SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-003 The block SHALL have ports: G1,Y1,R1,G2,Y2,R2  in  1 each  observed lamp drives of the two-way signal controller.
REQ-004 The block SHALL have ports: Tgreen, Tyellow  in  6 each  expected phase lengths in clk cycles.
REQ-005 The block SHALL have ports: clr_err  in  1  synchronous clear of sticky errors.
REQ-006 The block SHALL have ports: phase  out  2  current phase index; phase_len  out  8  length of the last completed phase; len_phase  out  2  index of that phase; len_valid  out  1  one-cycle strobe.
REQ-007 The block SHALL have ports: err_timing, err_seq, err_illegal  out  1 each  sticky flags; locked  out  1  tracking active; cycles_done  out  8  completed full cycles.

Function
REQ-008 Pattern {G1,Y1,R1,G2,Y2,R2} decodes as: 100001=P0, 010001=P1, 001100=P2, 001010=P3, 000000=OFF, all others ILLEGAL.
REQ-009 Legal order SHALL be P0->P1->P2->P3->P0; expected lengths: P0,P2 = Tgreen; P1,P3 = Tyellow, sampled on the edge the phase ends.
REQ-010 Lamp inputs SHALL be registered into lights_q (reset 000000); a change is detected when the input differs from lights_q at a rising edge.
REQ-011 Run counter SHALL count edges the current pattern has been held: set to 1 on the change edge, +1 per stable edge, saturating at 255.
REQ-012 FSM states SHALL be IDLE, TRACK, FAULT; locked=1 only in TRACK.
REQ-013 IDLE: OFF and other legal patterns are ignored; on the edge the input changes into P0, go TRACK, run=1, phase=0.
REQ-014 TRACK, on a change edge from phase Pk: phase_len<=run, len_phase<=k, len_valid=1 for exactly one cycle.
REQ-015 In the same edge, run != expected(k) SHALL set err_timing; an expected value of 0 always mismatches.
REQ-016 In the same edge, a new pattern that is not the successor of Pk (including OFF) SHALL set err_seq and return to IDLE; otherwise phase<=successor index.
REQ-017 A change edge P3->P0 SHALL increment cycles_done modulo 256 (255 wraps to 0).
REQ-018 An ILLEGAL input in any state SHALL set err_illegal and enter FAULT; no len_valid is issued on that edge (illegal has priority over timing/sequence checks).
REQ-019 FAULT SHALL hold until clr_err=1, then go IDLE; lamp inputs are ignored except for lights_q update.
REQ-020 clr_err SHALL clear all three error flags; if a new error is detected on the same edge, the new error flag SHALL remain set.
REQ-021 Errors SHALL not stop timing checks in TRACK; all outputs SHALL be registered, with one-edge latency from input change to len_valid.

Reset
REQ-022 On rst: state=IDLE, lights_q=000000, run=0, phase=0, phase_len=0, len_phase=0, len_valid=0, all err flags=0, locked=0, cycles_done=0.
REQ-023 Reset asserted mid-phase SHALL abandon the phase without a len_valid strobe; after release, tracking resumes only at the next entry into P0.

Verification
REQ-024 Tgreen=5, Tyellow=2; lamps OFF 3 cycles, then P0x5,P1x2,P2x5,P3x2, P0 -> four len_valid strobes with phase_len 5,2,5,2 and len_phase 0,1,2,3; cycles_done=1; no errors; locked=1 from the first P0 edge.
REQ-025 Same settings, P0 held 6 cycles -> phase_len=6, err_timing=1, tracking continues; clr_err pulse -> err_timing=0.
REQ-026 In TRACK, P0 followed directly by P2 -> err_seq=1, locked=0, state IDLE; next entry into P0 relocks.
REQ-027 Pattern 100100 (both greens) for one cycle -> err_illegal=1, no len_valid, locked=0; stays FAULT until clr_err, then IDLE.
REQ-028 P0 held 300 cycles with Tgreen=63 -> phase_len=255 (saturated), err_timing=1; rst asserted mid-P1 -> all outputs at reset values immediately, no strobe.
REQ-029 Run 256 correct full cycles -> cycles_done wraps to 0 after the 256th P3->P0 transition.
